// File: rtl/mem_port_arbiter.sv
// Single-port memory arbiter between instruction fetch and load/store, one transaction in flight.
// Optional feature: define MEM_ARB_RR_EN for round-robin on contention (default: data over fetch).
module mem_port_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                if_req,
  input  logic [ADDR_W-1:0]   if_addr,
  output logic                if_gnt,
  output logic                if_rvalid,
  output logic [DATA_W-1:0]   if_rdata,
  input  logic                d_req,
  input  logic                d_we,
  input  logic [ADDR_W-1:0]   d_addr,
  input  logic [DATA_W-1:0]   d_wdata,
  input  logic [DATA_W/8-1:0] d_be,
  output logic                d_gnt,
  output logic                d_rvalid,
  output logic [DATA_W-1:0]   d_rdata,
  output logic                mem_req,
  output logic                mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W/8-1:0] mem_be,
  input  logic                mem_ready,
  input  logic                mem_rvalid,
  input  logic [DATA_W-1:0]   mem_rdata,
  output logic                stall,
  output logic                busy
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] WAIT_I = 2'd1;
  localparam logic [1:0] WAIT_D = 2'd2;

  logic [1:0] state;
  logic [1:0] state_nxt;
  logic       pick_d;
  logic       issue;
  logic       accept;

`ifdef MEM_ARB_RR_EN
  logic last_d;

  // On contention the requester that did not win last time goes first.
  always_comb pick_d = d_req & (~if_req | ~last_d);

  always_ff @(posedge clk) begin
    if (reset)
      last_d <= 1'b0;
    else if (accept)
      last_d <= pick_d;
  end
`else
  // The data access belongs to the older instruction, so it always wins.
  always_comb pick_d = d_req;
`endif

  assign issue  = ~reset & (state == IDLE) & (if_req | d_req);
  assign accept = issue & mem_ready;

  always_comb begin
    mem_req   = issue;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    mem_be    = '0;
    if (issue) begin
      if (pick_d) begin
        mem_we    = d_we;
        mem_addr  = d_addr;
        mem_wdata = d_wdata;
        mem_be    = d_be;
      end else begin
        mem_addr  = if_addr;
        mem_be    = '1;
      end
    end
  end

  assign if_gnt    = accept & ~pick_d;
  assign d_gnt     = accept & pick_d;
  // Responses arriving outside a WAIT state are dropped.
  assign if_rvalid = ~reset & (state == WAIT_I) & mem_rvalid;
  assign d_rvalid  = ~reset & (state == WAIT_D) & mem_rvalid;
  assign if_rdata  = if_rvalid ? mem_rdata : '0;
  assign d_rdata   = d_rvalid ? mem_rdata : '0;
  assign busy      = ~reset & (state != IDLE);
  assign stall     = ~reset & ((if_req & ~if_rvalid) | (d_req & ~d_rvalid));

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = pick_d ? WAIT_D : WAIT_I;
      WAIT_I,
      WAIT_D:  if (mem_rvalid) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset)
      state <= IDLE;
    else
      state <= state_nxt;
  end

endmodule
